// File: rtl/pr_update_coalescer.sv
// Packs update words from PIPE_NUM round-robin lanes into WDATA_W-wide beats
// with incrementing addresses; a flush pads the final partial beat and ends the run.
module pr_update_coalescer #(
   parameter int FIFO_WIDTH = 64,
   parameter int PIPE_NUM   = 4,
   parameter int PIPE_NUM_W = 2,
   parameter int WDATA_W    = 512,
   parameter int ADDR_W     = 32,
   parameter logic [ADDR_W-1:0]     BASE_ADDR = '0,
   parameter logic [FIFO_WIDTH-1:0] PAD_WORD  = '1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           flush,
   input  logic [PIPE_NUM*FIFO_WIDTH-1:0] RData,
   input  logic [PIPE_NUM-1:0]            RDataV,
   output logic [PIPE_NUM-1:0]            RReady,
   output logic [WDATA_W-1:0]             WData,
   output logic                           WDataV,
   input  logic                           w_en,
   output logic [ADDR_W-1:0]              WAddr,
   output logic                           done,
   output logic [31:0]                    edge_cnt,
   output logic [31:0]                    beat_cnt
);
   localparam int SLOTS  = WDATA_W / FIFO_WIDTH;
   localparam int CNT_W  = $clog2(SLOTS + 1);
   localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int PTR_W  = (PIPE_NUM_W > 0) ? PIPE_NUM_W : 1;
   localparam int P2     = 2 * PIPE_NUM;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

   state_t                  r_state;
   logic [CNT_W-1:0]        r_cnt;
   logic [PTR_W-1:0]        r_ptr;
   logic [FIFO_WIDTH-1:0]   r_pack [SLOTS];
   logic [WDATA_W-1:0]      r_wdata;
   logic                    r_wdatav;
   logic [ADDR_W-1:0]       r_waddr;
   logic                    r_done;
   logic [31:0]             r_edge_cnt;
   logic [31:0]             r_beat_cnt;

   logic                    w_full;
   logic                    w_drain;
   logic                    w_out_free;
   logic                    w_flush_pad;
   logic                    w_move;
   logic                    w_can_accept;
   logic                    w_accept;
   logic [PIPE_NUM-1:0]     w_ptr_oh;
   logic [PIPE_NUM-1:0]     w_low_mask;
   logic [P2-1:0]           w_req2;
   logic [P2-1:0]           w_first;
   logic [PIPE_NUM-1:0]     w_grant;
   logic [PTR_W-1:0]        w_grant_idx;
   logic [PTR_W-1:0]        w_ptr_next;
   logic [FIFO_WIDTH-1:0]   w_word;
   logic [SLOT_W-1:0]       w_wr_slot;
   logic [WDATA_W-1:0]      w_beat;

   assign w_full      = (r_cnt == CNT_W'(SLOTS));
   assign w_drain     = r_wdatav & w_en;
   assign w_out_free  = ~r_wdatav | w_en;
   assign w_flush_pad = (r_state == S_FLUSH) && (r_cnt != '0);
   assign w_move      = (w_full | w_flush_pad) & w_out_free;
   // A completed buffer that moves out this cycle can already take the next word in slot 0.
   assign w_can_accept = (r_state == S_RUN) && (!w_full || w_move) && !rst;

   // Round-robin: requests at/above the pointer in the low half win before wrapped ones.
   assign w_ptr_oh   = PIPE_NUM'(1) << r_ptr;
   assign w_low_mask = w_ptr_oh - PIPE_NUM'(1);
   assign w_req2     = {RDataV, RDataV & ~w_low_mask};
   assign w_first    = w_req2 & (~w_req2 + P2'(1));
   assign w_grant    = w_first[PIPE_NUM-1:0] | w_first[P2-1:PIPE_NUM];

   assign RReady   = w_can_accept ? w_grant : '0;
   assign w_accept = |RReady;

   always_comb begin
      w_grant_idx = '0;
      w_word      = '0;
      for (int j = 0; j < PIPE_NUM; j++) begin
         if (w_grant[j]) begin
            w_grant_idx = w_grant_idx | PTR_W'(j);
            w_word      = w_word | RData[j*FIFO_WIDTH +: FIFO_WIDTH];
         end
      end
   end

   assign w_ptr_next = (w_grant_idx == PTR_W'(PIPE_NUM - 1)) ? '0 : w_grant_idx + 1'b1;
   assign w_wr_slot  = w_move ? '0 : r_cnt[SLOT_W-1:0];

   for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      assign w_beat[gi*FIFO_WIDTH +: FIFO_WIDTH] = (CNT_W'(gi) < r_cnt) ? r_pack[gi] : PAD_WORD;
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_pack[w_wr_slot] <= w_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_ptr      <= '0;
         r_wdata    <= '0;
         r_wdatav   <= 1'b0;
         r_waddr    <= BASE_ADDR;
         r_done     <= 1'b0;
         r_edge_cnt <= '0;
         r_beat_cnt <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_drain) begin
            r_wdatav   <= 1'b0;
            r_waddr    <= r_waddr + ADDR_W'(WDATA_W / 8);
            r_beat_cnt <= r_beat_cnt + 32'd1;
         end
         if (w_move) begin
            r_wdata  <= w_beat;
            r_wdatav <= 1'b1;
            r_cnt    <= w_accept ? CNT_W'(1) : '0;
         end else if (w_accept) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_accept) begin
            r_edge_cnt <= r_edge_cnt + 32'd1;
            r_ptr      <= w_ptr_next;
         end
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state    <= S_RUN;
                  r_cnt      <= '0;
                  r_ptr      <= '0;
                  r_edge_cnt <= '0;
                  r_beat_cnt <= '0;
                  r_waddr    <= BASE_ADDR;
               end
            end
            S_RUN: begin
               if (flush) r_state <= S_FLUSH;
            end
            S_FLUSH: begin
               if (r_cnt == '0 && !r_wdatav) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign WData    = r_wdata;
   assign WDataV   = r_wdatav;
   assign WAddr    = r_waddr;
   assign done     = r_done;
   assign edge_cnt = r_edge_cnt;
   assign beat_cnt = r_beat_cnt;
endmodule

// File: tb/tb_pr_update_coalescer.sv
// Bench for pr_update_coalescer: table of runs plus backpressure and mid-run reset
// sequences, checked against a scoreboard of expected beats.
module tb_pr_update_coalescer;
   localparam int FW = 64;
   localparam int PN = 4;
   localparam int WW = 512;
   localparam int AW = 32;
   localparam int SL = 8;

   logic              clk = 1'b0;
   logic              rst, start, flush, w_en;
   logic [PN*FW-1:0]  RData;
   logic [PN-1:0]     RDataV, RReady;
   logic [WW-1:0]     WData;
   logic              WDataV;
   logic [AW-1:0]     WAddr;
   logic              done;
   logic [31:0]       edge_cnt, beat_cnt;

   pr_update_coalescer dut (
      .clk(clk), .rst(rst), .start(start), .flush(flush),
      .RData(RData), .RDataV(RDataV), .RReady(RReady),
      .WData(WData), .WDataV(WDataV), .w_en(w_en), .WAddr(WAddr),
      .done(done), .edge_cnt(edge_cnt), .beat_cnt(beat_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WW-1:0] data;
      logic [AW-1:0] addr;
   } beat_t;

   typedef struct {
      int          n;
      logic [3:0]  mask;
      bit          poke_start;
      int          exp_beats;
      int          exp_edge;
   } vec_t;

   int n_pass = 0;
   int n_checks = 0;

   logic [FW-1:0] lane_word [PN];
   logic [PN-1:0] lane_v;
   logic [PN-1:0] last_acc;
   logic [PN-1:0] last_blocked_rr;
   int            to_load;
   int            k;
   logic [FW-1:0] word_q [$];
   beat_t         beat_q [$];
   logic [AW-1:0] m_addr;
   int            m_ptr, m_beats, done_seen, blocked_acc, onehot_err, stab_err, beats_out;
   bit            m_running;
   logic          prev_hold;
   logic [WW-1:0] prev_data;
   logic [AW-1:0] prev_addr;

   function automatic void check(string name, logic [WW-1:0] act, logic [WW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endfunction

   function automatic void load_lane(int l);
      if (to_load > 0) begin
         lane_word[l] = {32'(k + 1), 32'(k)};
         lane_v[l] = 1'b1;
         k++;
         to_load--;
      end else begin
         lane_v[l] = 1'b0;
      end
   endfunction

   function automatic void drive();
      RDataV = lane_v;
      for (int l = 0; l < PN; l++) RData[l*FW +: FW] = lane_word[l];
   endfunction

   function automatic void push_beat();
      beat_t b;
      b.data = '1;
      for (int s = 0; s < SL; s++) begin
         if (word_q.size() > 0) b.data[s*FW +: FW] = word_q.pop_front();
      end
      b.addr = m_addr;
      m_addr = m_addr + AW'(64);
      m_beats++;
      beat_q.push_back(b);
   endfunction

   // Called mid-cycle: records every transfer that the coming rising edge performs.
   task automatic observe();
      int exp_l;
      int got_l;
      beat_t b;
      last_acc = RReady & RDataV;
      if ($countones(RReady) > 1) onehot_err++;
      if (!w_en) last_blocked_rr = RReady;
      if (last_acc != '0) begin
         exp_l = -1;
         got_l = -1;
         for (int i = 0; i < PN; i++) begin
            if (exp_l < 0 && RDataV[(m_ptr + i) % PN]) exp_l = (m_ptr + i) % PN;
            if (last_acc[i]) got_l = i;
         end
         check("grant_lane", WW'(got_l), WW'(exp_l));
         word_q.push_back(lane_word[got_l]);
         m_ptr = (got_l + 1) % PN;
         if (!w_en) blocked_acc++;
         if (word_q.size() == SL) push_beat();
      end
      if (flush && m_running) begin
         m_running = 0;
         if (word_q.size() > 0) push_beat();
      end
      if (WDataV === 1'b1 && w_en) begin
         if (beat_q.size() == 0) begin
            check("unexpected_beat", 1, 0);
         end else begin
            b = beat_q.pop_front();
            check("beat_data", WData, b.data);
            check("beat_addr", WAddr, b.addr);
            $display("beat %0d addr=0x%0h data[63:0]=0x%0h", beats_out, WAddr, WData[63:0]);
            beats_out++;
         end
      end
      if (prev_hold === 1'b1) begin
         if (!(WDataV === 1'b1 && WData === prev_data && WAddr === prev_addr)) stab_err++;
      end
      prev_hold = WDataV & ~w_en;
      prev_data = WData;
      prev_addr = WAddr;
      if (done === 1'b1) done_seen++;
   endtask

   task automatic cycle();
      #1;
      observe();
      @(negedge clk);
      for (int l = 0; l < PN; l++) begin
         if (last_acc[l]) load_lane(l);
      end
      drive();
   endtask

   task automatic begin_run(int n, logic [3:0] mask, int wen_low);
      k = 0;
      to_load = n;
      m_addr = '0;
      m_ptr = 0;
      m_beats = 0;
      done_seen = 0;
      blocked_acc = 0;
      onehot_err = 0;
      stab_err = 0;
      lane_v = '0;
      for (int l = 0; l < PN; l++) if (mask[l]) load_lane(l);
      drive();
      start = 1'b1;
      w_en = (wen_low > 0) ? 1'b0 : 1'b1;
      m_running = 1;
      cycle();
      start = 1'b0;
   endtask

   task automatic stream(int wen_low, bit poke);
      int cyc = 0;
      while ((to_load > 0 || lane_v != '0) && cyc < 500) begin
         start = (poke && cyc == 5);
         w_en = (cyc < wen_low) ? 1'b0 : 1'b1;
         cycle();
         cyc++;
      end
      start = 1'b0;
      w_en = 1'b1;
      check("words_sent_in_budget", WW'(cyc < 500), 1);
   endtask

   task automatic finish_run(int exp_beats, int exp_edge);
      int cyc = 0;
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      while (done_seen == 0 && cyc < 200) begin
         cycle();
         cyc++;
      end
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      repeat (4) cycle();
      check("done_pulses", WW'(done_seen), 1);
      check("edge_cnt", edge_cnt, WW'(exp_edge));
      check("beat_cnt", beat_cnt, WW'(exp_beats));
      check("model_beats", WW'(m_beats), WW'(exp_beats));
      check("beats_pending", WW'(beat_q.size()), 0);
      check("rready_onehot", WW'(onehot_err), 0);
      check("hold_stable", WW'(stab_err), 0);
   endtask

   vec_t tbl [5];

   initial begin
      tbl[0] = '{n: 8,  mask: 4'b0001, poke_start: 1'b0, exp_beats: 1, exp_edge: 8};
      tbl[1] = '{n: 16, mask: 4'b1111, poke_start: 1'b1, exp_beats: 2, exp_edge: 16};
      tbl[2] = '{n: 3,  mask: 4'b0101, poke_start: 1'b0, exp_beats: 1, exp_edge: 3};
      tbl[3] = '{n: 16, mask: 4'b0011, poke_start: 1'b0, exp_beats: 2, exp_edge: 16};
      tbl[4] = '{n: 13, mask: 4'b1010, poke_start: 1'b0, exp_beats: 2, exp_edge: 13};

      rst = 1'b1; start = 1'b0; flush = 1'b0; w_en = 1'b1;
      lane_v = '0; to_load = 0; k = 0; beats_out = 0; m_running = 0; prev_hold = 1'b0;
      for (int l = 0; l < PN; l++) lane_word[l] = '0;
      drive();
      repeat (3) cycle();
      rst = 1'b0;
      lane_v = 4'hF;
      drive();
      cycle();
      check("reset_wdatav", WW'(WDataV), 0);
      check("reset_done", WW'(done), 0);
      check("reset_edge_cnt", edge_cnt, 0);
      check("reset_beat_cnt", beat_cnt, 0);
      check("reset_waddr", WAddr, 0);
      check("idle_rready", WW'(RReady), 0);
      lane_v = '0;
      drive();
      cycle();

      for (int t = 0; t < 5; t++) begin
         begin_run(tbl[t].n, tbl[t].mask, 0);
         stream(0, tbl[t].poke_start);
         finish_run(tbl[t].exp_beats, tbl[t].exp_edge);
      end

      // Output stalled for 25 cycles while all lanes stream.
      begin_run(24, 4'b1111, 25);
      stream(25, 1'b0);
      check("accepts_while_stalled", WW'(blocked_acc), 16);
      check("rready_when_stalled_full", WW'(last_blocked_rr), 0);
      finish_run(3, 24);

      // Reset after 5 words: partial beat must vanish.
      begin_run(5, 4'b0001, 0);
      stream(0, 1'b0);
      rst = 1'b1;
      lane_word[0] = 64'hDEAD_BEEF_0000_0000;
      lane_v = 4'b0001;
      drive();
      cycle();
      rst = 1'b0;
      word_q.delete();
      beat_q.delete();
      m_running = 0;
      cycle();
      check("rst_mid_wdatav", WW'(WDataV), 0);
      check("rst_mid_edge_cnt", edge_cnt, 0);
      check("rst_mid_beat_cnt", beat_cnt, 0);
      check("rst_mid_idle_rready", WW'(RReady), 0);
      lane_v = '0;
      drive();
      cycle();
      begin_run(8, 4'b0001, 0);
      stream(0, 1'b0);
      finish_run(1, 8);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
